// File: rtl/rom_link_pkg.sv
// Shared definitions for the rom_front <-> rom_backend byte link:
// link byte type, default FIFO sizing and an elaboration-time log2 helper.
package rom_link_pkg;

   localparam int LINK_DW       = 8;
   localparam int LINK_DEPTH    = 16;
   localparam int LINK_AF_LEVEL = 2;
   localparam int LINK_AE_LEVEL = 0;

   typedef logic [LINK_DW-1:0] link_byte_t;

   // Number of address bits needed to index DEPTH entries (DEPTH a power of 2).
   function automatic int clog2_depth(input int depth);
      int bits;
      bits = 0;
      while ((1 << bits) < depth) begin
         bits = bits + 1;
      end
      return bits;
   endfunction

endpackage : rom_link_pkg

// File: rtl/rom_link_ram.sv
// Storage for the link FIFO: DEPTH x DW array with one write port and one
// registered read port. Contents are never cleared; only the read register resets.
module rom_link_ram
   import rom_link_pkg::*;
#(
   parameter int DW    = LINK_DW,
   parameter int DEPTH = LINK_DEPTH,
   parameter int AW    = clog2_depth(LINK_DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read-before-write on a shared address: a read and write to the same
   // entry on one edge returns the old contents, which the full-and-both case relies on.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule : rom_link_ram

// File: rtl/rom_link_fifo.sv
// Synchronous byte FIFO for the rom_front <-> rom_backend link.
// Define ROM_LINK_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module rom_link_fifo
   import rom_link_pkg::*;
#(
   parameter int DW       = LINK_DW,
   parameter int DEPTH    = LINK_DEPTH,
   parameter int AF_LEVEL = LINK_AF_LEVEL,
   parameter int AE_LEVEL = LINK_AE_LEVEL
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [DW-1:0]          din,
   output logic                   almost_full,
   input  logic                   rd_en,
   output logic [DW-1:0]          dout,
   output logic                   almost_empty,
   output logic [$clog2(DEPTH):0] count
`ifdef ROM_LINK_FIFO_ERR_EN
   ,
   output logic                   overflow,
   output logic                   underflow
`endif
);

   localparam int AW = clog2_depth(DEPTH);

   localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
   localparam logic [AW:0] FULL_XOR  = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] AF_THRESH = (AW+1)'(DEPTH - AF_LEVEL);
   localparam logic [AW:0] AE_THRESH = (AW+1)'(AE_LEVEL);

   // Link handshake: wr_en/din and rd_en are single-cycle requests sampled on
   // the rising edge. A write is taken when the FIFO is not full or a read is
   // taken on the same edge; a read is taken when not empty and its byte
   // appears on dout the following cycle. Writers stop on almost_full and
   // readers on almost_empty; requests outside those limits are dropped, not stalled.

   logic [AW:0] wptr;
   logic [AW:0] rptr;
   logic        full;
   logic        empty;
   logic        rd_accept;
   logic        wr_accept;

   assign full  = ((wptr ^ rptr) == FULL_XOR);
   assign empty = (wptr == rptr);
   assign count = wptr - rptr;

   assign rd_accept = rd_en && !empty && !rst;
   assign wr_accept = wr_en && (!full || rd_accept) && !rst;

   assign almost_full  = (count >= AF_THRESH);
   assign almost_empty = (count <= AE_THRESH);

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_accept) begin
            wptr <= wptr + PTR_ONE;
         end
         if (rd_accept) begin
            rptr <= rptr + PTR_ONE;
         end
      end
   end

`ifdef ROM_LINK_FIFO_ERR_EN
   // Sticky until reset so firmware can sample them long after the event.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en && !wr_accept) begin
            overflow <= 1'b1;
         end
         if (rd_en && empty) begin
            underflow <= 1'b1;
         end
      end
   end
`endif

   rom_link_ram #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_accept),
      .waddr (wptr[AW-1:0]),
      .wdata (din),
      .re    (rd_accept),
      .raddr (rptr[AW-1:0]),
      .rdata (dout)
   );

endmodule : rom_link_fifo
